alu_unit: RTL and testbench

- Registered 8-bit combinational-function ALU for the lab datapath.
- Takes two operands a and b and a function select f, and produces result y and a zero flag.
- Implements AND, OR, add, subtract and set-less-than, with optional b inversion (Harris-style encoding).
- Outputs are registered on the single clock.

---
 rtl/alu_unit.sv | 43 ++++
 tb/tb_alu_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// Registered ALU: AND/OR/ADD/SUB/SLT with optional B inversion.
// Result and zero flag update one clock after the operands are sampled.
module alu_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] y_next;

    assign bb = f[2] ? ~b : b;
    // f[2] doubles as carry-in so that invert-plus-one yields a - b
    assign s  = a + bb + {{(WIDTH-1){1'b0}}, f[2]};

    always_comb begin
        y_next = '0;
        unique case (f[1:0])
            2'b00: y_next = a & bb;
            2'b01: y_next = a | bb;
            2'b10: y_next = s;
            2'b11: y_next = {{(WIDTH-1){1'b0}}, s[WIDTH-1]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y    <= '0;
            zero <= 1'b1;
        end else begin
            y    <= y_next;
            zero <= (y_next == '0);
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit using an expected-result queue.
module tb_alu_unit;

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] f;
    logic [7:0] y;
    logic       zero;

    int errors;
    int checks;

    logic [7:0] exp_q[$];

    alu_unit #(.WIDTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .f    (f),
        .y    (y),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] ta,
                                         input logic [7:0] tb,
                                         input logic [2:0] tf);
        logic [7:0] t;
        case (tf)
            3'b000: model = ta & tb;
            3'b001: model = ta | tb;
            3'b010: model = ta + tb;
            3'b011: begin
                t = ta + tb;
                model = {7'd0, t[7]};
            end
            3'b100: model = ta & ~tb;
            3'b101: model = ta | ~tb;
            3'b110: model = ta - tb;
            default: begin
                t = ta - tb;
                model = {7'd0, t[7]};
            end
        endcase
    endfunction

    task automatic step(input logic [7:0] ta, input logic [7:0] tb,
                        input logic [2:0] tf, input string tag);
        logic [7:0] e;
        a = ta;
        b = tb;
        f = tf;
        exp_q.push_back(model(ta, tb, tf));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_q"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_y"}, {24'd0, y}, {24'd0, e});
            check({tag, "_z"}, {31'd0, zero}, {31'd0, (e == 8'h00)});
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        a = 8'hFF;
        b = 8'h01;
        f = 3'b010;

        #2 reset = 1'b1;
        #1;
        check("rst_y", {24'd0, y}, 32'h0);
        check("rst_z", {31'd0, zero}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        step(8'hFF, 8'h01, 3'b010, "rel_wrap");

        step(8'hF0, 8'h3C, 3'b000, "and");
        step(8'hF0, 8'h3C, 3'b001, "or");
        step(8'h0F, 8'hF0, 3'b000, "and0");
        step(8'h7F, 8'h01, 3'b010, "add80");
        step(8'hFF, 8'h01, 3'b010, "addwrap");
        step(8'h05, 8'h07, 3'b110, "subneg");
        step(8'h2A, 8'h2A, 3'b110, "subzero");
        step(8'h03, 8'h05, 3'b111, "slt1");
        step(8'h05, 8'h03, 3'b111, "slt0");
        step(8'hFF, 8'h01, 3'b111, "sltneg");
        step(8'hC3, 8'h0F, 3'b100, "andnot");
        step(8'h10, 8'hFE, 3'b101, "ornot");
        step(8'hC0, 8'h50, 3'b011, "unused");

        step(8'h11, 8'h22, 3'b010, "pipe0");
        step(8'h80, 8'h01, 3'b110, "pipe1");
        step(8'hAA, 8'h55, 3'b001, "pipe2");
        step(8'h01, 8'h02, 3'b111, "pipe3");

        for (int i = 0; i < 24; i++) begin
            step(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), "rand");
        end

        step(8'h7F, 8'h01, 3'b010, "pre_rst");
        a = 8'h01;
        b = 8'h01;
        f = 3'b010;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_y", {24'd0, y}, 32'h0);
        check("mid_rst_z", {31'd0, zero}, 32'h1);
        @(posedge clk);
        #1;
        check("hold_rst_y", {24'd0, y}, 32'h0);
        check("hold_rst_z", {31'd0, zero}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        step(8'h01, 8'h01, 3'b010, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
